core_mem_arbiter: RTL and testbench

//  Shares one external memory port between the core's instruction-fetch (mem_i_*) and data (mem_d_*) ports.

---
 rtl/core_mem_arb_pkg.sv | 24 ++
 rtl/core_mem_arb_rr.sv | 41 ++++
 rtl/core_mem_arbiter.sv | 224 ++++++++++++++++++++++
 tb/tb_core_mem_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// core_mem_arb_pkg
//   Shared types and constants for the core memory arbiter.
//   - state_t : arbiter FSM states
//   - side_t  : which core port owns the current transaction
//   - STRB_W  : byte-strobe width of the D side and the external port
// -----------------------------------------------------------------------------
package core_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    SIDE_I = 1'b0,
    SIDE_D = 1'b1
  } side_t;

  localparam int STRB_W = 4;

endpackage

// File: rtl/core_mem_arb_rr.sv
// -----------------------------------------------------------------------------
// core_mem_arb_rr
//   Two-way grant picker for the core memory arbiter.
//   Ports:
//     req_i   [1:0]  request vector, bit 0 = I side, bit 1 = D side
//     last_q         side granted at the most recent accept (0 = I, 1 = D)
//     grant_o        chosen side (0 = I, 1 = D); only meaningful when req_i != 0
//   Configuration:
//     MEM_ARB_DPRIO_EN defined   : fixed priority, D always wins contention
//     MEM_ARB_DPRIO_EN undefined : round-robin, the side not granted last wins
// -----------------------------------------------------------------------------
module core_mem_arb_rr
  import core_mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_q,
  output logic       grant_o
);

`ifdef MEM_ARB_DPRIO_EN
  // Fixed priority keeps no history.
  logic unused_last;
  assign unused_last = last_q;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    grant_o = SIDE_I;
    if (req_i[1]) grant_o = SIDE_D;
  end
`else
  always_comb begin
    grant_o = SIDE_I;
    if (req_i == 2'b11) begin
      grant_o = (last_q == SIDE_D) ? SIDE_I : SIDE_D;
    end else if (req_i[1]) begin
      grant_o = SIDE_D;
    end
  end
`endif

endmodule

// File: rtl/core_mem_arbiter.sv
// -----------------------------------------------------------------------------
// core_mem_arbiter
//   Shares one external memory port between the core's instruction-fetch
//   (mem_i_*) and data (mem_d_*) ports. One transaction outstanding, 2-way
//   arbitration on contention. D-side maintenance ops (flush / invalidate /
//   writeback) complete locally without touching the external port; I-side
//   flush / invalidate are accepted and dropped.
//
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     mem_i_*                  fetch port: request in, accept / valid / error / inst out
//     mem_d_*                  data port: addr / wdata / rd / strobes / tag / maintenance in,
//                              accept / ack / error / rdata / resp tag out
//     ext_req_o .. ext_wr_o    external request (ext_wr_o == 0 means read)
//     ext_accept_i             external request taken (only looked at in ISSUE)
//     ext_ack_i, ext_rdata_i,
//     ext_error_i              external response (only looked at in WAIT)
//
//   Configuration: define MEM_ARB_DPRIO_EN for fixed D-priority arbitration
//   (see core_mem_arb_rr); default is round-robin.
// -----------------------------------------------------------------------------
module core_mem_arbiter
  import core_mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 11
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              mem_i_rd_i,
  input  logic              mem_i_flush_i,
  input  logic              mem_i_invalidate_i,
  input  logic [ADDR_W-1:0] mem_i_pc_i,
  output logic              mem_i_accept_o,
  output logic              mem_i_valid_o,
  output logic              mem_i_error_o,
  output logic [DATA_W-1:0] mem_i_inst_o,

  input  logic [ADDR_W-1:0] mem_d_addr_i,
  input  logic [DATA_W-1:0] mem_d_data_wr_i,
  input  logic              mem_d_rd_i,
  input  logic [STRB_W-1:0] mem_d_wr_i,
  input  logic              mem_d_cacheable_i,
  input  logic [TAG_W-1:0]  mem_d_req_tag_i,
  input  logic              mem_d_invalidate_i,
  input  logic              mem_d_writeback_i,
  input  logic              mem_d_flush_i,
  output logic              mem_d_accept_o,
  output logic              mem_d_ack_o,
  output logic              mem_d_error_o,
  output logic [DATA_W-1:0] mem_d_data_rd_o,
  output logic [TAG_W-1:0]  mem_d_resp_tag_o,

  output logic              ext_req_o,
  output logic [ADDR_W-1:0] ext_addr_o,
  output logic [DATA_W-1:0] ext_wdata_o,
  output logic [STRB_W-1:0] ext_wr_o,
  input  logic              ext_accept_i,
  input  logic              ext_ack_i,
  input  logic [DATA_W-1:0] ext_rdata_i,
  input  logic              ext_error_i
);

  // Cacheability is informational only.
  logic unused_cacheable;
  assign unused_cacheable = mem_d_cacheable_i;

  state_t              state_q,      state_d;
  side_t               last_grant_q, last_grant_d;
  side_t               side_q,       side_d;
  logic [ADDR_W-1:0]   addr_q,       addr_d;
  logic [DATA_W-1:0]   wdata_q,      wdata_d;
  logic [STRB_W-1:0]   wr_q,         wr_d;
  logic [TAG_W-1:0]    tag_q,        tag_d;
  logic                err_q,        err_d;
  logic [DATA_W-1:0]   inst_q,       inst_d;
  logic [DATA_W-1:0]   d_data_q,     d_data_d;
  logic [TAG_W-1:0]    resp_tag_q,   resp_tag_d;

  logic i_req, d_req, d_is_ext;
  logic grant;
  logic can_accept, i_accept, d_accept;

  assign i_req    = mem_i_rd_i | mem_i_flush_i | mem_i_invalidate_i;
  assign d_req    = mem_d_rd_i | (|mem_d_wr_i) | mem_d_invalidate_i
                  | mem_d_writeback_i | mem_d_flush_i;
  // Anything other than a read or a write is a maintenance op served locally.
  assign d_is_ext = mem_d_rd_i | (|mem_d_wr_i);

  core_mem_arb_rr u_rr (
    .req_i   ({d_req, i_req}),
    .last_q  (last_grant_q),
    .grant_o (grant)
  );

  // Accept is combinational from the requests in the IDLE cycle; reset masks it.
  assign can_accept = (state_q == IDLE) && !rst;
  assign i_accept   = can_accept && i_req && (grant == SIDE_I);
  assign d_accept   = can_accept && d_req && (grant == SIDE_D);

  // ---------------------------------------------------------------------------
  // State register (also holds the captured request and response registers)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state is written with non-blocking assignments only, so every flop samples pre-edge values.
      state_q      <= IDLE;
      last_grant_q <= SIDE_D;
      side_q       <= SIDE_I;
      addr_q       <= '0;
      wdata_q      <= '0;
      wr_q         <= '0;
      tag_q        <= '0;
      err_q        <= 1'b0;
      inst_q       <= '0;
      d_data_q     <= '0;
      resp_tag_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      side_q       <= side_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wr_q         <= wr_d;
      tag_q        <= tag_d;
      err_q        <= err_d;
      inst_q       <= inst_d;
      d_data_q     <= d_data_d;
      resp_tag_q   <= resp_tag_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (i_accept && mem_i_rd_i) state_d = ISSUE;
        else if (d_accept)          state_d = d_is_ext ? ISSUE : RESP;
      end
      ISSUE:   if (ext_accept_i) state_d = WAIT;
      WAIT:    if (ext_ack_i)    state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request capture and response datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    last_grant_d = last_grant_q;
    side_d       = side_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wr_d         = wr_q;
    tag_d        = tag_q;
    err_d        = err_q;
    inst_d       = inst_q;
    d_data_d     = d_data_q;
    resp_tag_d   = resp_tag_q;

    if (i_accept) begin
      last_grant_d = SIDE_I;
      side_d       = SIDE_I;
      addr_d       = mem_i_pc_i;
      wdata_d      = '0;
      wr_d         = '0;
    end else if (d_accept) begin
      last_grant_d = SIDE_D;
      side_d       = SIDE_D;
      addr_d       = mem_d_addr_i;
      wdata_d      = mem_d_data_wr_i;
      wr_d         = mem_d_wr_i;
      tag_d        = mem_d_req_tag_i;
      // Maintenance op: the response is fully known now, load it for RESP.
      if (!d_is_ext) begin
        err_d      = 1'b0;
        d_data_d   = '0;
        resp_tag_d = mem_d_req_tag_i;
      end
    end

    // Response registers load only on the edge into RESP, so the data and tag
    // outputs hold their last value outside response cycles.
    if (state_q == WAIT && ext_ack_i) begin
      err_d = ext_error_i;
      if (side_q == SIDE_I) begin
        inst_d = ext_rdata_i;
      end else begin
        d_data_d   = (wr_q != '0) ? '0 : ext_rdata_i;
        resp_tag_d = tag_q;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  logic in_resp;

  always_comb begin
    in_resp        = (state_q == RESP) && !rst;
    ext_req_o      = (state_q == ISSUE) && !rst;
    mem_i_accept_o = i_accept;
    mem_d_accept_o = d_accept;
    mem_i_valid_o  = in_resp && (side_q == SIDE_I);
    mem_d_ack_o    = in_resp && (side_q == SIDE_D);
    mem_i_error_o  = mem_i_valid_o && err_q;
    mem_d_error_o  = mem_d_ack_o && err_q;
  end

  assign ext_addr_o       = addr_q;
  assign ext_wdata_o      = wdata_q;
  assign ext_wr_o         = wr_q;
  assign mem_i_inst_o     = inst_q;
  assign mem_d_data_rd_o  = d_data_q;
  assign mem_d_resp_tag_o = resp_tag_q;

endmodule

// File: tb/tb_core_mem_arbiter.sv
`timescale 1ns/1ps
module tb_core_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_i_rd_i, mem_i_flush_i, mem_i_invalidate_i;
  logic [31:0] mem_i_pc_i;
  logic        mem_i_accept_o, mem_i_valid_o, mem_i_error_o;
  logic [31:0] mem_i_inst_o;
  logic [31:0] mem_d_addr_i, mem_d_data_wr_i;
  logic        mem_d_rd_i;
  logic [3:0]  mem_d_wr_i;
  logic        mem_d_cacheable_i;
  logic [10:0] mem_d_req_tag_i;
  logic        mem_d_invalidate_i, mem_d_writeback_i, mem_d_flush_i;
  logic        mem_d_accept_o, mem_d_ack_o, mem_d_error_o;
  logic [31:0] mem_d_data_rd_o;
  logic [10:0] mem_d_resp_tag_o;
  logic        ext_req_o;
  logic [31:0] ext_addr_o, ext_wdata_o;
  logic [3:0]  ext_wr_o;
  logic        ext_accept_i, ext_ack_i, ext_error_i;
  logic [31:0] ext_rdata_i;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  core_mem_arbiter dut (
    .clk                (clk),
    .rst                (rst),
    .mem_i_rd_i         (mem_i_rd_i),
    .mem_i_flush_i      (mem_i_flush_i),
    .mem_i_invalidate_i (mem_i_invalidate_i),
    .mem_i_pc_i         (mem_i_pc_i),
    .mem_i_accept_o     (mem_i_accept_o),
    .mem_i_valid_o      (mem_i_valid_o),
    .mem_i_error_o      (mem_i_error_o),
    .mem_i_inst_o       (mem_i_inst_o),
    .mem_d_addr_i       (mem_d_addr_i),
    .mem_d_data_wr_i    (mem_d_data_wr_i),
    .mem_d_rd_i         (mem_d_rd_i),
    .mem_d_wr_i         (mem_d_wr_i),
    .mem_d_cacheable_i  (mem_d_cacheable_i),
    .mem_d_req_tag_i    (mem_d_req_tag_i),
    .mem_d_invalidate_i (mem_d_invalidate_i),
    .mem_d_writeback_i  (mem_d_writeback_i),
    .mem_d_flush_i      (mem_d_flush_i),
    .mem_d_accept_o     (mem_d_accept_o),
    .mem_d_ack_o        (mem_d_ack_o),
    .mem_d_error_o      (mem_d_error_o),
    .mem_d_data_rd_o    (mem_d_data_rd_o),
    .mem_d_resp_tag_o   (mem_d_resp_tag_o),
    .ext_req_o          (ext_req_o),
    .ext_addr_o         (ext_addr_o),
    .ext_wdata_o        (ext_wdata_o),
    .ext_wr_o           (ext_wr_o),
    .ext_accept_i       (ext_accept_i),
    .ext_ack_i          (ext_ack_i),
    .ext_rdata_i        (ext_rdata_i),
    .ext_error_i        (ext_error_i)
  );

  typedef struct {
    string       name;
    bit          is_d;
    logic        rd;
    logic        flush;
    logic        inval;
    logic        wb;
    logic [3:0]  wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [10:0] tag;
    int          dly;       // cycles ext_accept_i is withheld
    logic [31:0] rdata;
    logic        err;
    bit          exp_ext;   // external transaction expected
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_i();
    mem_i_rd_i = 0; mem_i_flush_i = 0; mem_i_invalidate_i = 0; mem_i_pc_i = '0;
  endtask

  task automatic clear_d();
    mem_d_rd_i = 0; mem_d_wr_i = '0; mem_d_addr_i = '0; mem_d_data_wr_i = '0;
    mem_d_req_tag_i = '0; mem_d_invalidate_i = 0; mem_d_writeback_i = 0; mem_d_flush_i = 0;
  endtask

  // Called right after the accept was checked in the IDLE cycle. Plays the
  // external memory and checks request hold, latency, response pulse and hold.
  task automatic bus_cycle(input string name, input bit is_d, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wr, input int dly,
                           input logic [31:0] rdata, input logic err,
                           input logic [31:0] exp_data, input logic exp_err,
                           input logic [10:0] tag);
    @(negedge clk);
    if (is_d) clear_d(); else clear_i();
    for (int k = 0; k <= dly; k++) begin
      ext_accept_i = (k == dly);
      #1;
      check({name, "_ext_req"}, 32'(ext_req_o), 1);
      check({name, "_ext_addr"}, ext_addr_o, addr);
      check({name, "_ext_wr"}, 32'(ext_wr_o), 32'(wr));
      if (wr != 4'h0) check({name, "_ext_wdata"}, ext_wdata_o, wdata);
      @(negedge clk);
    end
    ext_accept_i = 0; ext_ack_i = 1; ext_rdata_i = rdata; ext_error_i = err;
    #1;
    check({name, "_ext_req_drop"}, 32'(ext_req_o), 0);
    check({name, "_early_resp"}, 32'(is_d ? mem_d_ack_o : mem_i_valid_o), 0);
    @(negedge clk);
    ext_ack_i = 0; ext_rdata_i = '0; ext_error_i = 0;
    #1;
    check({name, "_resp"}, 32'(is_d ? mem_d_ack_o : mem_i_valid_o), 1);
    check({name, "_data"}, is_d ? mem_d_data_rd_o : mem_i_inst_o, exp_data);
    check({name, "_err"}, 32'(is_d ? mem_d_error_o : mem_i_error_o), 32'(exp_err));
    if (is_d) check({name, "_tag"}, 32'(mem_d_resp_tag_o), 32'(tag));
    @(negedge clk);
    #1;
    check({name, "_resp_end"}, 32'(is_d ? mem_d_ack_o : mem_i_valid_o), 0);
    check({name, "_err_end"}, 32'(is_d ? mem_d_error_o : mem_i_error_o), 0);
    check({name, "_data_hold"}, is_d ? mem_d_data_rd_o : mem_i_inst_o, exp_data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit first_d;
    vec_t v;

    //          name              d  rd fl in wb wr     addr          wdata         tag     dly rdata         err ext exp_data      exp_err
    vecs[0] = '{"i_rd_pc100",     0, 1, 0, 0, 0, 4'h0, 32'h00000100, 32'h0,        11'h000, 0, 32'h00000013, 0,  1, 32'h00000013, 0};
    vecs[1] = '{"d_rd",           1, 1, 0, 0, 0, 4'h0, 32'h00003000, 32'h0,        11'h012, 1, 32'hCAFEF00D, 0,  1, 32'hCAFEF00D, 0};
    vecs[2] = '{"d_wr_0011",      1, 0, 0, 0, 0, 4'h3, 32'h00002000, 32'hDEADBEEF, 11'h005, 0, 32'h55555555, 0,  1, 32'h00000000, 0};
    vecs[3] = '{"d_flush",        1, 0, 1, 0, 0, 4'h0, 32'h00000000, 32'h0,        11'h7FF, 0, 32'h0,        0,  0, 32'h00000000, 0};
    vecs[4] = '{"d_rd_err_dly3",  1, 1, 0, 0, 0, 4'h0, 32'h00004000, 32'h0,        11'h003, 3, 32'h0BADBAD0, 1,  1, 32'h0BADBAD0, 1};
    vecs[5] = '{"d_wr_with_rd",   1, 1, 0, 0, 0, 4'hF, 32'h00002004, 32'h12345678, 11'h1AB, 2, 32'hFFFFFFFF, 0,  1, 32'h00000000, 0};
    vecs[6] = '{"i_rd_err",       0, 1, 0, 0, 0, 4'h0, 32'h00000104, 32'h0,        11'h000, 0, 32'h00000077, 1,  1, 32'h00000077, 1};
    vecs[7] = '{"i_flush_local",  0, 0, 1, 0, 0, 4'h0, 32'h00000108, 32'h0,        11'h000, 0, 32'h0,        0,  0, 32'h00000000, 0};
    vecs[8] = '{"d_writeback",    1, 0, 0, 0, 1, 4'h0, 32'h00000040, 32'h0,        11'h400, 0, 32'h0,        0,  0, 32'h00000000, 0};
    vecs[9] = '{"d_invalidate",   1, 0, 0, 1, 0, 4'h0, 32'h00000080, 32'h0,        11'h001, 0, 32'h0,        0,  0, 32'h00000000, 0};

    rst = 1;
    clear_i(); clear_d();
    mem_d_cacheable_i = 0;
    ext_accept_i = 0; ext_ack_i = 0; ext_rdata_i = '0; ext_error_i = 0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_ext_req", 32'(ext_req_o), 0);
    check("rst_i_valid", 32'(mem_i_valid_o), 0);
    check("rst_d_ack", 32'(mem_d_ack_o), 0);
    check("rst_inst", mem_i_inst_o, 0);
    check("rst_d_data", mem_d_data_rd_o, 0);
    check("rst_tag", 32'(mem_d_resp_tag_o), 0);
    check("rst_ext_addr", ext_addr_o, 0);
    @(negedge clk);
    rst = 0;

    // Contention straight after reset: last_grant=D, so I wins unless D has priority.
`ifdef MEM_ARB_DPRIO_EN
    first_d = 1'b1;
`else
    first_d = 1'b0;
`endif
    mem_i_rd_i = 1; mem_i_pc_i = 32'h180;
    mem_d_rd_i = 1; mem_d_addr_i = 32'h5000; mem_d_req_tag_i = 11'h02A;
    #1;
    check("cont_i_accept", 32'(mem_i_accept_o), 32'(!first_d));
    check("cont_d_accept", 32'(mem_d_accept_o), 32'(first_d));
    if (first_d) bus_cycle("cont_first_d", 1, 32'h5000, 32'h0, 4'h0, 0, 32'h22222222, 0, 32'h22222222, 0, 11'h02A);
    else         bus_cycle("cont_first_i", 0, 32'h180, 32'h0, 4'h0, 0, 32'h11111111, 0, 32'h11111111, 0, 11'h000);
    check("cont2_i_accept", 32'(mem_i_accept_o), 32'(first_d));
    check("cont2_d_accept", 32'(mem_d_accept_o), 32'(!first_d));
    if (first_d) bus_cycle("cont_second_i", 0, 32'h180, 32'h0, 4'h0, 0, 32'h11111111, 0, 32'h11111111, 0, 11'h000);
    else         bus_cycle("cont_second_d", 1, 32'h5000, 32'h0, 4'h0, 0, 32'h22222222, 0, 32'h22222222, 0, 11'h02A);

    // Single-requester vectors
    for (int n = 0; n < 10; n++) begin
      v = vecs[n];
      if (v.is_d) begin
        mem_d_rd_i = v.rd; mem_d_wr_i = v.wr; mem_d_addr_i = v.addr; mem_d_data_wr_i = v.wdata;
        mem_d_req_tag_i = v.tag; mem_d_flush_i = v.flush; mem_d_invalidate_i = v.inval;
        mem_d_writeback_i = v.wb;
      end else begin
        mem_i_rd_i = v.rd; mem_i_flush_i = v.flush; mem_i_invalidate_i = v.inval; mem_i_pc_i = v.addr;
      end
      #1;
      check({v.name, "_accept"}, 32'(v.is_d ? mem_d_accept_o : mem_i_accept_o), 1);
      check({v.name, "_other_accept"}, 32'(v.is_d ? mem_i_accept_o : mem_d_accept_o), 0);
      if (v.exp_ext) begin
        bus_cycle(v.name, v.is_d, v.addr, v.wdata, v.is_d ? v.wr : 4'h0, v.dly,
                  v.rdata, v.err, v.exp_data, v.exp_err, v.tag);
      end else if (v.is_d) begin
        @(negedge clk);
        clear_d();
        #1;
        check({v.name, "_no_ext_req"}, 32'(ext_req_o), 0);
        check({v.name, "_ack"}, 32'(mem_d_ack_o), 1);
        check({v.name, "_tag"}, 32'(mem_d_resp_tag_o), 32'(v.tag));
        check({v.name, "_data"}, mem_d_data_rd_o, 0);
        check({v.name, "_err"}, 32'(mem_d_error_o), 0);
        @(negedge clk);
        #1;
        check({v.name, "_ack_end"}, 32'(mem_d_ack_o), 0);
        check({v.name, "_tag_hold"}, 32'(mem_d_resp_tag_o), 32'(v.tag));
      end else begin
        @(negedge clk);
        clear_i();
        #1;
        check({v.name, "_no_ext_req"}, 32'(ext_req_o), 0);
        check({v.name, "_no_valid"}, 32'(mem_i_valid_o), 0);
        @(negedge clk);
        #1;
        check({v.name, "_no_valid2"}, 32'(mem_i_valid_o), 0);
      end
    end

    // Reset while WAITing; a late ack must be ignored
    mem_d_rd_i = 1; mem_d_addr_i = 32'h6000; mem_d_req_tag_i = 11'h055;
    #1;
    check("rstw_accept", 32'(mem_d_accept_o), 1);
    @(negedge clk);
    clear_d();
    ext_accept_i = 1;
    #1;
    check("rstw_ext_req", 32'(ext_req_o), 1);
    @(negedge clk);
    ext_accept_i = 0;
    rst = 1;
    #1;
    check("rstw_ext_req_in_rst", 32'(ext_req_o), 0);
    check("rstw_ack_in_rst", 32'(mem_d_ack_o), 0);
    @(negedge clk);
    ext_ack_i = 1; ext_rdata_i = 32'h99999999;
    #1;
    check("rstw_ack", 32'(mem_d_ack_o), 0);
    check("rstw_valid", 32'(mem_i_valid_o), 0);
    check("rstw_inst", mem_i_inst_o, 0);
    check("rstw_d_data", mem_d_data_rd_o, 0);
    check("rstw_tag", 32'(mem_d_resp_tag_o), 0);
    check("rstw_ext_addr", ext_addr_o, 0);
    @(negedge clk);
    rst = 0;
    #1;
    check("rstw_idle_ack_ignored", 32'(mem_d_ack_o), 0);
    @(negedge clk);
    ext_ack_i = 0; ext_rdata_i = '0;
    #1;
    check("rstw_idle_ack_ignored2", 32'(mem_d_ack_o), 0);
    check("rstw_idle_no_req", 32'(ext_req_o), 0);
    mem_i_rd_i = 1; mem_i_pc_i = 32'h200;
    #1;
    check("rstw_next_accept", 32'(mem_i_accept_o), 1);
    bus_cycle("rstw_next", 0, 32'h200, 32'h0, 4'h0, 0, 32'h00000033, 0, 32'h00000033, 0, 11'h000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
